// File: rtl/iodelay_tap_loader.sv
// IDELAYE2 VAR_LOAD tap programmer: default init after IDELAYCTRL RDY, then on request.
// Optional macro IODELAY_TAP_READBACK_EN adds a CNTVALUEOUT readback check per load.
module iodelay_tap_loader #(
    parameter int num_lanes_p     = 5,
    parameter int tap_width_p     = 5,
    parameter int default_tap_p   = 0,
    parameter int settle_cycles_p = 4,
    localparam int lg_lanes_lp    = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               rdy_i,
    input  logic                               req_v_i,
    output logic                               req_ready_o,
    input  logic [lg_lanes_lp-1:0]             req_lane_i,
    input  logic [tap_width_p-1:0]             req_tap_i,
    output logic [num_lanes_p-1:0]             ld_o,
    output logic [tap_width_p-1:0]             cntvaluein_o,
    input  logic [num_lanes_p*tap_width_p-1:0] cntvalueout_i,
    output logic                               done_v_o,
    output logic [tap_width_p-1:0]             done_tap_o,
    output logic                               done_err_o,
    output logic                               delay_ready_o
);

    typedef enum logic [2:0] {
        WAIT_RDY,
        INIT,
        INIT_SETTLE,
        IDLE,
        LOAD,
        SETTLE,
`ifdef IODELAY_TAP_READBACK_EN
        CHECK,
`endif
        RESP
    } state_e;

    localparam logic [lg_lanes_lp:0] lanes_lp = (lg_lanes_lp+1)'(num_lanes_p);
    localparam logic [lg_lanes_lp-1:0] last_lane_lp = lg_lanes_lp'(num_lanes_p - 1);
    localparam logic [3:0] settle_last_lp = 4'(settle_cycles_p - 1);
    localparam logic [tap_width_p-1:0] default_tap_lp = tap_width_p'(default_tap_p);

    (* ASYNC_REG = "TRUE" *) logic rdy_meta;
    (* ASYNC_REG = "TRUE" *) logic rdy_s;

    state_e                   state_q, state_d;
    logic [lg_lanes_lp-1:0]   lane_q;
    logic [tap_width_p-1:0]   tap_q;
    logic [3:0]               cnt_q;
    logic [tap_width_p-1:0]   cntval_q;
    logic [tap_width_p-1:0]   done_tap_q;
    logic                     done_err_q;
    logic                     delay_ready_q;

    logic settle_done;
    logic lane_ok;
    logic req_lane_ok;
    logic ld_en;

    assign settle_done = (cnt_q == settle_last_lp);
    assign lane_ok     = ({1'b0, lane_q} < lanes_lp);
    assign req_lane_ok = ({1'b0, req_lane_i} < lanes_lp);

`ifdef IODELAY_TAP_READBACK_EN
    logic [tap_width_p-1:0] rb_tap;
    always_comb begin
        rb_tap = '0;
        for (int i = 0; i < num_lanes_p; i++) begin
            if (lane_q == lg_lanes_lp'(i)) begin
                rb_tap = cntvalueout_i[i*tap_width_p +: tap_width_p];
            end
        end
    end
`else
    logic unused_cntvalueout;
    assign unused_cntvalueout = ^cntvalueout_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= rdy_i;
            rdy_s    <= rdy_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= WAIT_RDY;
        end else begin
            state_q <= state_d;
        end
    end

    // Loss of RDY pre-empts every state, dropping any in-flight request.
    always_comb begin
        state_d = state_q;
        if (!rdy_s && state_q != WAIT_RDY) begin
            state_d = WAIT_RDY;
        end else begin
            unique case (state_q)
                WAIT_RDY:    if (rdy_s) state_d = INIT;
                INIT:        state_d = INIT_SETTLE;
                INIT_SETTLE: begin
                    if (settle_done) begin
                        state_d = (lane_q == last_lane_lp) ? IDLE : INIT;
                    end
                end
                IDLE:        if (req_v_i) state_d = LOAD;
                LOAD:        state_d = lane_ok ? SETTLE : RESP;
                SETTLE: begin
`ifdef IODELAY_TAP_READBACK_EN
                    if (settle_done) state_d = CHECK;
`else
                    if (settle_done) state_d = RESP;
`endif
                end
`ifdef IODELAY_TAP_READBACK_EN
                CHECK:       state_d = RESP;
`endif
                RESP:        state_d = IDLE;
                default:     state_d = WAIT_RDY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lane_q        <= '0;
            tap_q         <= '0;
            cnt_q         <= '0;
            cntval_q      <= '0;
            done_tap_q    <= '0;
            done_err_q    <= 1'b0;
            delay_ready_q <= 1'b0;
        end else begin
            if ((state_q == INIT_SETTLE || state_q == SETTLE) && !settle_done) begin
                cnt_q <= cnt_q + 4'd1;
            end else begin
                cnt_q <= '0;
            end

            if (state_q == WAIT_RDY) begin
                lane_q <= '0;
            end else if (state_q == INIT_SETTLE && settle_done) begin
                lane_q <= lane_q + 1'b1;
            end else if (state_q == IDLE && req_v_i) begin
                lane_q <= req_lane_i;
                tap_q  <= req_tap_i;
            end

            // CNTVALUEIN is set one cycle ahead so it is stable with LD.
            if (state_d == INIT) begin
                cntval_q <= default_tap_lp;
            end else if (state_q == IDLE && req_v_i && req_lane_ok) begin
                cntval_q <= req_tap_i;
            end

            if (state_q == LOAD) begin
                done_tap_q <= tap_q;
                done_err_q <= !lane_ok;
            end
`ifdef IODELAY_TAP_READBACK_EN
            if (state_q == CHECK) begin
                done_tap_q <= rb_tap;
                done_err_q <= (rb_tap != tap_q);
            end
`endif

            delay_ready_q <= (state_d != WAIT_RDY) && (state_d != INIT) &&
                             (state_d != INIT_SETTLE);
        end
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        done_v_o    = (state_q == RESP);
        ld_en       = (state_q == INIT) || (state_q == LOAD && lane_ok);
        ld_o        = '0;
        for (int i = 0; i < num_lanes_p; i++) begin
            ld_o[i] = ld_en && (lane_q == lg_lanes_lp'(i));
        end
    end

    assign cntvaluein_o  = cntval_q;
    assign done_tap_o    = done_tap_q;
    assign done_err_o    = done_err_q;
    assign delay_ready_o = delay_ready_q;

endmodule

// File: tb/tb_iodelay_tap_loader.sv
// Directed bench for iodelay_tap_loader: init sequence, requests, RDY loss, reset.
// Honours IODELAY_TAP_READBACK_EN when computing expected latency and readback.
module tb_iodelay_tap_loader;

    localparam int S = 4;

`ifdef IODELAY_TAP_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        rdy;
    logic        req_v;
    logic        req_ready;
    logic [2:0]  req_lane;
    logic [4:0]  req_tap;
    logic [4:0]  ld;
    logic [4:0]  cntvaluein;
    logic [24:0] cntvalueout;
    logic        done_v;
    logic [4:0]  done_tap;
    logic        done_err;
    logic        delay_ready;

    logic [4:0]  lane_tap [5];
    logic [4:0]  xor_mask;

    int checks;
    int passed;

    iodelay_tap_loader #(
        .num_lanes_p(5),
        .tap_width_p(5),
        .default_tap_p(0),
        .settle_cycles_p(S)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .rdy_i(rdy),
        .req_v_i(req_v),
        .req_ready_o(req_ready),
        .req_lane_i(req_lane),
        .req_tap_i(req_tap),
        .ld_o(ld),
        .cntvaluein_o(cntvaluein),
        .cntvalueout_i(cntvalueout),
        .done_v_o(done_v),
        .done_tap_o(done_tap),
        .done_err_o(done_err),
        .delay_ready_o(delay_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // IDELAYE2 model: latches CNTVALUEIN on LD, optionally corrupted.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (ld[i]) lane_tap[i] <= cntvaluein ^ xor_mask;
        end
    end

    always_comb begin
        cntvalueout = '0;
        for (int i = 0; i < 5; i++) cntvalueout[i*5 +: 5] = lane_tap[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rdy = 1'b0;
        req_v = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, ld, cntvaluein, done_v, done_tap, done_err, delay_ready} !== '0)
            $display("FAIL reset_outputs got rr=%b ld=%b cv=%0d dv=%b dt=%0d de=%b dr=%b want all 0",
                     req_ready, ld, cntvaluein, done_v, done_tap, done_err, delay_ready);
        else passed++;
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({delay_ready, req_ready, ld} !== 7'd0)
                $display("FAIL idle_no_rdy cycle %0d got dr=%b rr=%b ld=%b want 0 0 00000",
                         c, delay_ready, req_ready, ld);
            else passed++;
        end
    endtask

    task automatic test_init();
        int n;
        logic [4:0] exp_ld;
        n = 0;
        while (ld == 5'd0 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (ld == 5'd0) $display("FAIL init_start got no LD within 12 cycles want LD pulse");
        else passed++;
        for (int i = 0; i < 5; i++) begin
            exp_ld = 5'b00001 << i;
            checks++;
            if (ld !== exp_ld || cntvaluein !== 5'd0 || delay_ready !== 1'b0)
                $display("FAIL init_ld lane %0d got ld=%b cv=%0d dr=%b want ld=%b cv=0 dr=0",
                         i, ld, cntvaluein, delay_ready, exp_ld);
            else passed++;
            for (int k = 1; k <= S + 1; k++) begin
                tick();
                if (k <= S) begin
                    checks++;
                    if (ld !== 5'd0 || delay_ready !== 1'b0)
                        $display("FAIL init_settle lane %0d k %0d got ld=%b dr=%b want 00000 0",
                                 i, k, ld, delay_ready);
                    else passed++;
                end
            end
        end
        checks++;
        if (delay_ready !== 1'b1 || req_ready !== 1'b1)
            $display("FAIL init_done got dr=%b rr=%b want 1 1", delay_ready, req_ready);
        else passed++;
    endtask

    task automatic test_legal();
        int n;
        xor_mask = 5'd0;
        req_lane = 3'd2;
        req_tap = 5'd17;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        checks++;
        if (ld !== 5'b00100 || cntvaluein !== 5'd17 || done_v !== 1'b0)
            $display("FAIL legal_ld got ld=%b cv=%0d dv=%b want 00100 17 0", ld, cntvaluein, done_v);
        else passed++;
        n = 1;
        while (!done_v && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2 + S + RB || done_tap !== 5'd17 || done_err !== 1'b0)
            $display("FAIL legal_done got cyc=%0d tap=%0d err=%b want %0d 17 0",
                     n, done_tap, done_err, 2 + S + RB);
        else passed++;
        tick();
        checks++;
        if (done_v !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL legal_pulse got dv=%b rr=%b want 0 1", done_v, req_ready);
        else passed++;
    endtask

    task automatic test_illegal_lane();
        req_lane = 3'd6;
        req_tap = 5'd9;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        checks++;
        if (ld !== 5'd0 || cntvaluein !== 5'd17)
            $display("FAIL illegal_ld got ld=%b cv=%0d want 00000 17", ld, cntvaluein);
        else passed++;
        tick();
        checks++;
        if (done_v !== 1'b1 || done_err !== 1'b1 || done_tap !== 5'd9 || ld !== 5'd0)
            $display("FAIL illegal_resp got dv=%b err=%b tap=%0d ld=%b want 1 1 9 00000",
                     done_v, done_err, done_tap, ld);
        else passed++;
        tick();
        checks++;
        if (done_v !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL illegal_pulse got dv=%b rr=%b want 0 1", done_v, req_ready);
        else passed++;
    endtask

    task automatic test_mismatch();
        int n;
        xor_mask = 5'd1;
        req_lane = 3'd3;
        req_tap = 5'd17;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        checks++;
        if (ld !== 5'b01000 || cntvaluein !== 5'd17)
            $display("FAIL mismatch_ld got ld=%b cv=%0d want 01000 17", ld, cntvaluein);
        else passed++;
        n = 1;
        while (!done_v && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (RB == 1) begin
            if (n !== 7 || done_tap !== 5'd16 || done_err !== 1'b1)
                $display("FAIL mismatch_done got cyc=%0d tap=%0d err=%b want 7 16 1",
                         n, done_tap, done_err);
            else passed++;
        end else begin
            if (n !== 6 || done_tap !== 5'd17 || done_err !== 1'b0)
                $display("FAIL mismatch_done got cyc=%0d tap=%0d err=%b want 6 17 0",
                         n, done_tap, done_err);
            else passed++;
        end
        xor_mask = 5'd0;
        tick();
    endtask

    task automatic test_rdy_drop();
        req_lane = 3'd1;
        req_tap = 5'd5;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        tick();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (done_v !== 1'b0)
                $display("FAIL drop_no_done cycle %0d got dv=%b want 0", c, done_v);
            else passed++;
        end
        checks++;
        if (delay_ready !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL drop_ready got dr=%b rr=%b want 0 0", delay_ready, req_ready);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (done_v !== 1'b0 || ld !== 5'd0 || delay_ready !== 1'b0)
                $display("FAIL drop_quiet cycle %0d got dv=%b ld=%b dr=%b want 0 00000 0",
                         c, done_v, ld, delay_ready);
            else passed++;
        end
        rdy = 1'b1;
        test_init();
    endtask

    task automatic test_reset_load();
        req_lane = 3'd0;
        req_tap = 5'd3;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        checks++;
        if (ld !== 5'b00001 || cntvaluein !== 5'd3)
            $display("FAIL rstload_ld got ld=%b cv=%0d want 00001 3", ld, cntvaluein);
        else passed++;
        reset_n = 1'b0;
        tick();
        checks++;
        if ({req_ready, ld, cntvaluein, done_v, done_tap, done_err, delay_ready} !== '0)
            $display("FAIL rstload_out got rr=%b ld=%b cv=%0d dv=%b dt=%0d de=%b dr=%b want all 0",
                     req_ready, ld, cntvaluein, done_v, done_tap, done_err, delay_ready);
        else passed++;
        reset_n = 1'b1;
        test_init();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        xor_mask = 5'd0;
        req_lane = 3'd0;
        req_tap = 5'd0;
        req_v = 1'b0;
        rdy = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) lane_tap[i] = 5'd0;
        test_reset();
        rdy = 1'b1;
        test_init();
        test_legal();
        test_illegal_lane();
        test_mismatch();
        test_rdy_drop();
        test_reset_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
